// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues single-word reads at PC, captures the returned
// instruction, pulses iready per completed fetch, and latches misalign/timeout errors.
`timescale 1ns/1ps
module instr_fetch #(
    parameter int unsigned       ADDR_W  = 32,
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       TIMEOUT = 16,
    parameter logic [DATA_W-1:0] NOP     = DATA_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic [ADDR_W-1:0] PC,
    input  logic              stall,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              iready,
    output logic              fetch_err,
    output logic [1:0]        err_code
);

    localparam int unsigned      CNT_W       = 8;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [1:0]       ERR_NONE    = 2'b00;
    localparam logic [1:0]       ERR_ALIGN   = 2'b01;
    localparam logic [1:0]       ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Fetch sequencer; ERR is terminal until reset, and stray acks are ignored outside REQ.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            fetch_req  <= 1'b0;
            fetch_addr <= '0;
            instr      <= NOP;
            iready     <= 1'b0;
            fetch_err  <= 1'b0;
            err_code   <= ERR_NONE;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!stall) begin
                        if (PC[1:0] != 2'b00) begin
                            fetch_err <= 1'b1;
                            err_code  <= ERR_ALIGN;
                            instr     <= NOP;
                            state     <= ERR;
                        end else begin
                            fetch_addr <= PC;
                            fetch_req  <= 1'b1;
                            wait_cnt   <= '0;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        instr     <= mem_rdata;
                        fetch_req <= 1'b0;
                        wait_cnt  <= '0;
                        iready    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        // Counter saturates; the TIMEOUT-th unacked REQ cycle ends the fetch.
                        if (wait_cnt != CNT_MAX) begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                        if (wait_cnt == CNT_LAST) begin
                            fetch_req <= 1'b0;
                            fetch_err <= 1'b1;
                            err_code  <= ERR_TIMEOUT;
                            instr     <= NOP;
                            state     <= ERR;
                        end
                    end
                end
                DONE: begin
                    iready <= 1'b0;
                    state  <= IDLE;
                end
                ERR: begin
                    fetch_req <= 1'b0;
                    iready    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a transaction-level expectation model
// checked every cycle, plus hand-computed latency/count/value checks.
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [31:0] NOP_VAL = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              nRST = 1'b0;
    logic [ADDR_W-1:0] PC = '0;
    logic              stall = 1'b0;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] instr;
    logic              iready;
    logic              fetch_err;
    logic [1:0]        err_code;

    instr_fetch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .NOP    (NOP_VAL)
    ) dut (
        .clk       (clk),
        .nRST      (nRST),
        .PC        (PC),
        .stall     (stall),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .fetch_req (fetch_req),
        .fetch_addr(fetch_addr),
        .instr     (instr),
        .iready    (iready),
        .fetch_err (fetch_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: what the architecturally visible registers must hold.
    logic [31:0] m_addr, m_instr;
    logic        m_err;
    logic [1:0]  m_code;
    // Per-cycle expectations derived from the transaction being driven.
    logic [31:0] e_addr, e_instr;
    logic        e_req, e_iready, e_err;
    logic [1:0]  e_code;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic set_exp(input logic req, input logic rdy);
        e_req    = req;
        e_iready = rdy;
        e_addr   = m_addr;
        e_instr  = m_instr;
        e_err    = m_err;
        e_code   = m_code;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparator against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            check("fetch_req",  32'(fetch_req), 32'(e_req));
            check("fetch_addr", fetch_addr,     e_addr);
            check("instr",      instr,          e_instr);
            check("iready",     32'(iready),    32'(e_iready));
            check("fetch_err",  32'(fetch_err), 32'(e_err));
            check("err_code",   32'(err_code),  32'(e_code));
        end
    end

    // Independent timing monitor feeding the hand-computed checks.
    int  cyc = 0, last_rise = 0, rise_gap = 0, hi_cnt = 0, lat = 0;
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (fetch_req && !prev_req) begin
            rise_gap  = cyc - last_rise;
            last_rise = cyc;
            hi_cnt    = 0;
        end
        if (fetch_req) hi_cnt++;
        if (iready) lat = cyc - last_rise + 1;
        prev_req = fetch_req;
    end

    task automatic do_reset;
        chk_en  = 1'b0;
        nRST    = 1'b0;
        mem_ack = 1'b0;
        stall   = 1'b0;
        next_cycle();
        next_cycle();
        check("rst_instr",     instr,          32'h0000_0013);
        check("rst_iready",    32'(iready),    32'd0);
        check("rst_fetch_req", 32'(fetch_req), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        m_addr  = '0;
        m_instr = NOP_VAL;
        m_err   = 1'b0;
        m_code  = 2'b00;
        nRST    = 1'b1;
        set_exp(1'b0, 1'b0);
        chk_en  = 1'b1;
    endtask

    // One fetch: IDLE launch cycle, waits+1 REQ cycles (ack on the last), DONE cycle.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input int waits, input bit stall_req, input bit spur);
        PC = addr; stall = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom;
        set_exp(1'b0, 1'b0);
        next_cycle();
        m_addr = addr;
        for (int i = 0; i <= waits; i++) begin
            stall     = stall_req;
            mem_ack   = (i == waits);
            mem_rdata = (i == waits) ? data : 32'($urandom);
            PC        = 32'($urandom);
            set_exp(1'b1, 1'b0);
            next_cycle();
        end
        m_instr = data;
        stall = 1'b0; mem_ack = spur; mem_rdata = ~data; PC = addr;
        set_exp(1'b0, 1'b1);
        next_cycle();
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Back-to-back zero-wait fetches; second launch is 3 cycles after the first.
        do_fetch(32'h100, 32'h00A0_0093, 0, 1'b0, 1'b0);
        check("zw_instr", instr, 32'h00A0_0093);
        check("zw_lat",   32'(lat), 32'd2);
        do_fetch(32'h104, 32'h0010_0113, 0, 1'b0, 1'b1);
        check("step_gap", 32'(rise_gap), 32'd3);

        // Stall in IDLE with spurious acks: nothing may move.
        for (int i = 0; i < 5; i++) begin
            PC = 32'h108; stall = 1'b1; mem_ack = i[0]; mem_rdata = $urandom;
            set_exp(1'b0, 1'b0);
            next_cycle();
        end

        do_fetch(32'h108, 32'hDEAD_BEE3, 4, 1'b0, 1'b0);
        check("ws_lat",   32'(lat),    32'd6);
        check("ws_hicnt", 32'(hi_cnt), 32'd5);
        do_fetch(32'h10C, 32'h1234_5678, 2, 1'b1, 1'b0);

        // Timeout: REQ for exactly TIMEOUT cycles, then sticky error.
        PC = 32'h110; stall = 1'b0; mem_ack = 1'b0;
        set_exp(1'b0, 1'b0);
        next_cycle();
        m_addr = 32'h110;
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            mem_ack = 1'b0; mem_rdata = $urandom;
            set_exp(1'b1, 1'b0);
            next_cycle();
        end
        m_err = 1'b1; m_code = 2'b10; m_instr = NOP_VAL;
        for (int i = 0; i < 6; i++) begin
            mem_ack = i[0]; mem_rdata = $urandom; PC = 32'h200;
            set_exp(1'b0, 1'b0);
            next_cycle();
        end
        check("to_hicnt", 32'(hi_cnt),   32'd16);
        check("to_code",  32'(err_code), 32'd2);
        check("to_instr", instr,         32'h0000_0013);

        // Misaligned PC: error one cycle after sampling, no request.
        do_reset();
        do_fetch(32'h300, 32'h0050_0293, 1, 1'b0, 1'b0);
        PC = 32'h102; mem_ack = 1'b0;
        set_exp(1'b0, 1'b0);
        next_cycle();
        m_err = 1'b1; m_code = 2'b01; m_instr = NOP_VAL;
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1; mem_rdata = $urandom; PC = 32'h104;
            set_exp(1'b0, 1'b0);
            next_cycle();
        end
        check("mis_code", 32'(err_code),  32'd1);
        check("mis_req",  32'(fetch_req), 32'd0);
        check("mis_addr", fetch_addr,     32'h300);

        // Asynchronous reset in the middle of a REQ cycle.
        do_reset();
        PC = 32'h400;
        set_exp(1'b0, 1'b0);
        next_cycle();
        m_addr = 32'h400;
        set_exp(1'b1, 1'b0);
        #2;
        chk_en = 1'b0;
        nRST   = 1'b0;
        #1;
        check("ar_req",   32'(fetch_req), 32'd0);
        check("ar_addr",  fetch_addr,     32'h0);
        check("ar_instr", instr,          32'h0000_0013);
        check("ar_rdy",   32'(iready),    32'd0);
        check("ar_err",   32'(fetch_err), 32'd0);
        check("ar_code",  32'(err_code),  32'd0);
        next_cycle();

        do_reset();
        do_fetch(32'h500, 32'hCAFE_0013, 0, 1'b0, 1'b0);
        check("rec_instr", instr, 32'hCAFE_0013);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit sitting directly downstream of `pc`. It takes the current `PC`, issues a single-word read on the instruction memory bus, and captures the returned instruction. It pulses `iready` back to `pc` (and the control unit) for exactly one cycle per completed fetch. It also detects misaligned PCs and bus timeouts, and latches them as a sticky error.

## Interface
Parameters:
- `ADDR_W`, 32, width of PC and bus address
- `DATA_W`, 32, instruction width
- `TIMEOUT`, 16, max wait cycles for `mem_ack` before error (≥1, ≤255)
- `NOP`, 32'h0000_0013, value driven on `instr` at reset and after an error (`addi x0,x0,0`)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `nRST`  in  1  reset, asynchronous, active-low
- `PC`  in  ADDR_W  current program counter from `pc`
- `stall`  in  1  shared bus in use by data path; blocks launching a new fetch
- `mem_ack`  in  1  memory read data valid this cycle
- `mem_rdata`  in  DATA_W  memory read data
- `fetch_req`  out  1  read request to instruction memory
- `fetch_addr`  out  ADDR_W  read address, stable while `fetch_req`=1
- `instr`  out  DATA_W  last fetched instruction (registered)
- `iready`  out  1  one-cycle pulse: `instr` valid for the PC that was fetched
- `fetch_err`  out  1  sticky error flag
- `err_code`  out  2  00 none, 01 misaligned PC, 10 timeout

## Operation
- FSM states: IDLE, REQ, DONE, ERR.
- Reset (async): state=IDLE. `fetch_req`=0, `fetch_addr`=0, `instr`=NOP, `iready`=0, `fetch_err`=0, `err_code`=00, wait counter=0.
- IDLE:
  - `stall`=1: stay in IDLE.
  - Else if `PC[1:0]`≠0: go to ERR with `err_code`=01.
  - Else: register `fetch_addr`=PC, set `fetch_req`=1, go to REQ.
- REQ:
  - `fetch_req`=1 and `fetch_addr` frozen.
  - On `mem_ack`=1: `instr`←`mem_rdata`, `fetch_req`←0, counter←0, go to DONE.
  - Else counter+1. When the counter reaches TIMEOUT with no ack: `fetch_req`←0, go to ERR with `err_code`=10.
  - `stall` is ignored in REQ; an issued request always completes or times out.
- DONE: `iready`=1 for this one cycle only, then IDLE. `pc` samples `iready` at the closing edge.
- ERR: terminal until `nRST`.
  - `fetch_err`=1, `instr`=NOP, `fetch_req`=0, `iready`=0.
  - Further `mem_ack` is ignored.
- `mem_ack` in IDLE, DONE or ERR is spurious: ignored, no state or output change.
- `instr` changes only on an accepted ack, on reset, or on entry to ERR.
- All outputs are registered; no combinational path from any input to any output.
- Counter width is 8 bits and saturates; it never wraps.

## Timing
- Minimum fetch: 3 cycles per instruction.
  - Cycle 0 (IDLE): PC sampled.
  - Cycle 1 (REQ): `fetch_req`=1, ack arrives.
  - Cycle 2 (DONE): `iready`=1, `instr` valid.
  - Cycle 3 (IDLE): sees the updated PC.
- Each extra memory wait cycle adds exactly one cycle.
- Timeout: with no ack, ERR is entered on the edge after TIMEOUT cycles in REQ.
  - REQ lasts exactly TIMEOUT cycles; `fetch_req` falls on that same edge.
- Misaligned PC: ERR is entered one cycle after IDLE samples it. No request is ever issued.
- `stall` deasserted in cycle n while in IDLE: `fetch_req` rises at the edge ending cycle n.
- Reset mid-REQ: `fetch_req` drops immediately (asynchronously). Memory must tolerate an abandoned request.
- `iready` is never high on two consecutive cycles.

## Test plan
- Reset: hold `nRST`=0 for 2 cycles → `instr`=32'h13, `iready`=0, `fetch_req`=0, `fetch_err`=0. Release → first `fetch_req` with `fetch_addr`=PC one cycle later.
- Zero-wait fetch: PC=0x100, ack with `mem_rdata`=0x00A00093 in the first REQ cycle → `iready` pulses the next cycle, `instr`=0x00A00093. Then step PC to 0x104 → next `fetch_addr`=0x104 three cycles after the first.
- Wait states: ack delayed 4 cycles → `fetch_addr` stable for all 5 REQ cycles, single `iready` pulse, latency 6 cycles.
- Stall: `stall`=1 for 5 cycles in IDLE → no `fetch_req`. Assert `stall` mid-REQ → request still completes on ack.
- Timeout: TIMEOUT=16, never ack → `fetch_req` high exactly 16 cycles, then `fetch_err`=1, `err_code`=10, `instr`=NOP. Later acks are ignored until reset.
- Misaligned PC=0x102 → no request, `err_code`=01 one cycle later. Async reset mid-REQ → all outputs at reset values before the next clock edge.
